lm_sm_sequencer: RTL

- Controller that sequences Load-Multiple / Store-Multiple instructions through the EX/MEM pipeline register.
- Takes one LM/SM from EX (base address plus 8-bit register list) and expands it into one micro-op per set list bit.
- Each micro-op carries M_addr, RDest, W_reg/W_mem and LMStart. Outputs drive the EX/MEM register's in_* ports.
- Stalls upstream stages until the last micro-op is issued.

---
 rtl/lm_sm_sequencer_pkg.sv | 21 ++
 rtl/lm_sm_sequencer_if.sv | 34 +++
 rtl/lm_sm_sequencer_lsb_pick.sv | 21 ++
 rtl/lm_sm_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared definitions for the LM/SM sequencer: sizes, FSM states and
// the LMStart encodings presented to the EX/MEM register.
package lm_sm_pkg;

  localparam int NREG = 8;
  localparam int AW   = 16;
  localparam int RW   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [1:0] lms_t;

  localparam lms_t LMS_IDLE  = 2'b00;
  localparam lms_t LMS_FIRST = 2'b01;
  localparam lms_t LMS_MID   = 2'b10;
  localparam lms_t LMS_LAST  = 2'b11;

endpackage

// File: rtl/lm_sm_sequencer_if.sv
// EX-side request and EX/MEM-side micro-op bundle of the LM/SM sequencer.
// master = pipeline/EX stage, slave = sequencer.
interface lm_sm_sequencer_if import lm_sm_pkg::*; ();

  logic            start;
  logic            is_sm;
  logic [AW-1:0]   base_addr;
  logic [NREG-1:0] reg_list;
  logic            hold;
  logic            flush;

  logic            uop_valid;
  logic [AW-1:0]   uop_addr;
  logic [RW-1:0]   uop_rdest;
  logic            uop_w_reg;
  logic            uop_w_mem;
  lms_t            uop_lmstart;
  logic            busy;
  logic            stall_upstream;
  logic            done;

  modport master (
    output start, is_sm, base_addr, reg_list, hold, flush,
    input  uop_valid, uop_addr, uop_rdest, uop_w_reg, uop_w_mem,
           uop_lmstart, busy, stall_upstream, done
  );

  modport slave (
    input  start, is_sm, base_addr, reg_list, hold, flush,
    output uop_valid, uop_addr, uop_rdest, uop_w_reg, uop_w_mem,
           uop_lmstart, busy, stall_upstream, done
  );

endinterface

// File: rtl/lm_sm_sequencer_lsb_pick.sv
// Lowest-set-bit priority encoder with any/multiple flags; also usable
// by the hazard unit on the same register list.
module lsb_pick import lm_sm_pkg::*; (
  input  logic [NREG-1:0] vec_i,
  output logic [RW-1:0]   idx_o,
  output logic            any_o,
  output logic            multi_o
);

  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx_o = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = RW'(i);
    end
  end

  assign any_o   = |vec_i;
  assign multi_o = (vec_i & (vec_i - NREG'(1))) != '0;

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM into one micro-op per set register-list bit, issued
// through the EX/MEM register on the falling edge like the pipeline regs.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no sequence open; a start issues its first micro-op at once
//   ST_RUN  | further list bits remain; one micro-op per non-held edge
module lm_sm_sequencer import lm_sm_pkg::*; (
  input  logic              clk,
  input  logic              resetn,
  lm_sm_sequencer_if.slave  bus
);

  state_e          state_q, state_d;
  logic [NREG-1:0] list_q, list_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            is_sm_q, is_sm_d;
  logic            last_q, last_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   uaddr_q, uaddr_d;
  logic [RW-1:0]   rdest_q, rdest_d;
  logic            wreg_q, wreg_d;
  logic            wmem_q, wmem_d;
  lms_t            lms_q, lms_d;
  logic            done_q, done_d;

  logic [NREG-1:0] pick_vec;
  logic [NREG-1:0] pick_onehot;
  logic [RW-1:0]   pick_idx;
  logic            pick_any;
  logic            pick_multi;

  // in IDLE the candidate list comes straight from EX, in RUN from the working copy
  assign pick_vec    = (state_q == ST_IDLE) ? bus.reg_list : list_q;
  assign pick_onehot = NREG'(1) << pick_idx;

  lsb_pick u_pick (
    .vec_i   (pick_vec),
    .idx_o   (pick_idx),
    .any_o   (pick_any),
    .multi_o (pick_multi)
  );

  // drop the stall in the cycle the final micro-op goes out
  assign bus.stall_upstream = (state_q == ST_IDLE) ? (bus.start & pick_multi)
                                                   : pick_multi;

  // next-state and micro-op generation; priority flush > hold > normal
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    is_sm_d = is_sm_q;
    last_d  = last_q;
    valid_d = valid_q;
    uaddr_d = uaddr_q;
    rdest_d = rdest_q;
    wreg_d  = wreg_q;
    wmem_d  = wmem_q;
    lms_d   = lms_q;
    done_d  = 1'b0;

    if (bus.flush) begin
      state_d = ST_IDLE;
      list_d  = '0;
      last_d  = 1'b0;
      valid_d = 1'b0;
      wreg_d  = 1'b0;
      wmem_d  = 1'b0;
      lms_d   = LMS_IDLE;
    end else if (!bus.hold) begin
      done_d  = last_q;
      last_d  = 1'b0;
      valid_d = 1'b0;
      wreg_d  = 1'b0;
      wmem_d  = 1'b0;
      lms_d   = LMS_IDLE;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (pick_any) begin
              valid_d = 1'b1;
              uaddr_d = bus.base_addr;
              rdest_d = pick_idx;
              wreg_d  = ~bus.is_sm;
              wmem_d  = bus.is_sm;
              is_sm_d = bus.is_sm;
              list_d  = bus.reg_list & ~pick_onehot;
              addr_d  = bus.base_addr + AW'(1);
              if (pick_multi) begin
                lms_d   = LMS_FIRST;
                state_d = ST_RUN;
              end else begin
                lms_d   = LMS_LAST;
                last_d  = 1'b1;
              end
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          valid_d = 1'b1;
          uaddr_d = addr_q;
          rdest_d = pick_idx;
          wreg_d  = ~is_sm_q;
          wmem_d  = is_sm_q;
          list_d  = list_q & ~pick_onehot;
          addr_d  = addr_q + AW'(1);
          if (pick_multi) begin
            lms_d = LMS_MID;
          end else begin
            lms_d   = LMS_LAST;
            last_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // falling-edge register bank with synchronous active-low reset
  always_ff @(negedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      is_sm_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      uaddr_q <= '0;
      rdest_q <= '0;
      wreg_q  <= 1'b0;
      wmem_q  <= 1'b0;
      lms_q   <= LMS_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      is_sm_q <= is_sm_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      uaddr_q <= uaddr_d;
      rdest_q <= rdest_d;
      wreg_q  <= wreg_d;
      wmem_q  <= wmem_d;
      lms_q   <= lms_d;
      done_q  <= done_d;
    end
  end

  assign bus.uop_valid   = valid_q;
  assign bus.uop_addr    = uaddr_q;
  assign bus.uop_rdest   = rdest_q;
  assign bus.uop_w_reg   = wreg_q;
  assign bus.uop_w_mem   = wmem_q;
  assign bus.uop_lmstart = lms_q;
  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = done_q;

endmodule
